spi_slave: RTL and testbench
============================

# spi_slave

Serial front end that feeds the single-port command RAM. Deserialises MOSI frames into 10-bit command words for the RAM's `rx_data`/`rx_valid` input, tracks the read-address / read-data sequence, and serialises the RAM's returned byte onto MISO. Sits between the external SPI master pins and the RAM inside the SPI wrapper. The SPI clock is `clk`; there is no separate SCK domain.

## Interface
- `DATA_W`, 10: command word width; bits [9:8] are the command, bits [7:0] are the payload.
- `TX_W`, 8: width of the read-back byte.
- `clk` in 1: system/SPI clock; all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `SS_n` in 1: slave select, active low, sampled on posedge.
- `MOSI` in 1: serial data in, MSB first.
- `MISO` out 1: serial data out, MSB first, registered.
- `rx_data` out `DATA_W`: assembled command word.
- `rx_valid` out 1: one-cycle strobe qualifying `rx_data`.
- `tx_data` in `TX_W`: read-back byte from RAM.
- `tx_valid` in 1: qualifies `tx_data`.

## Operation
- FSM states: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA. Internal flag `rd_addr_received`.
- IDLE: `MISO`=0. SS_n=0 -> CHK_CMD.
- CHK_CMD: sample MOSI as word bit 9. Bit9=0 -> WRITE. Bit9=1 and flag=0 -> READ_ADD. Bit9=1 and flag=1 -> READ_DATA.
- WRITE / READ_ADD / READ_DATA receive: shift in bits 8..0 on the next 9 posedges. A 4-bit counter tracks progress.
- After bit 0:
  - Load `rx_data` and pulse `rx_valid` for exactly 1 cycle.
  - READ_ADD sets the flag.
  - READ_DATA clears the flag.
  - WRITE and READ_ADD then hold until SS_n=1. Extra MOSI bits are ignored.
- READ_DATA transmit:
  - After its rx_valid pulse, wait for `tx_valid`=1.
  - On that posedge, capture `tx_data`.
  - Drive `MISO` with bits 7..0 on the following 8 cycles, one bit per cycle.
  - Then drive `MISO`=0 until SS_n=1.
  - `tx_valid` is ignored in every other state and phase.
- SS_n=1 on any posedge in a non-IDLE state:
  - Go to IDLE; clear counters and shift registers; `MISO`=0.
  - A partial frame produces no `rx_valid`.
  - The flag is preserved.

## Timing
- Reset (rst=1 at posedge): state IDLE, `MISO`=0, `rx_data`=0, `rx_valid`=0, flag=0. Reset overrides SS_n. Reset mid-frame aborts the frame with no strobe.
- Frame, taking posedge P0 as the first posedge with SS_n=0 in IDLE:
  - P1 samples bit 9.
  - P2..P10 sample bits 8..0.
  - `rx_valid`=1 in the cycle following P10, i.e. 10 cycles after CHK_CMD entry.
- Read-back: `tx_valid` sampled high at posedge T. `MISO` carries bit 7 after T+1, bit 0 after T+8, and returns to 0 after T+9.
- `tx_valid` in the same cycle as the `rx_valid` strobe is accepted.
- SS_n rising in the same cycle as bit 0 is sampled: the abort wins, with no strobe.
- Back-to-back frames: SS_n high for at least 1 cycle between frames. A new frame starts from IDLE.

## Configuration
- `SPI_CMD_CHECK_EN` defined:
  - At frame end, `rx_data[9:8]` must match the state: WRITE accepts 00/01, READ_ADD accepts 10, READ_DATA accepts 11.
  - On mismatch, `rx_valid` stays 0, the flag is unchanged and READ_DATA does not transmit.
- `SPI_CMD_CHECK_EN` undefined: no check; every completed frame strobes `rx_valid` and updates the flag.

## Test plan
- Reset, then a write-address frame with MOSI bits 00_1010_0101 -> `rx_data`=0x0A5, `rx_valid` high for 1 cycle exactly 10 cycles after CHK_CMD entry; `MISO`=0 throughout.
- Read-address frame 10_0000_0011, then a read-data frame 11_xxxx_xxxx, then `tx_valid`=1 with `tx_data`=0xC3 -> `MISO` sequence 1,1,0,0,0,0,1,1 starting 1 cycle after `tx_valid`; flag is 1 after the first frame and 0 after the second.
- Frame whose first bit is 1 while the flag is 0 -> enters READ_ADD, not READ_DATA; `MISO` stays 0 even with `tx_valid` pulsed.
- SS_n raised after 5 bits of a write frame -> no `rx_valid`; the next full frame decodes correctly.
- `rst` asserted mid read-back -> `MISO`=0 and `rx_valid`=0 next cycle; the flag is cleared.
- With `SPI_CMD_CHECK_EN`: READ_ADD frame carrying 11_0000_0001 -> no `rx_valid`, flag stays 0. Without the macro: strobe with `rx_data`=0x301 and flag set.

Source files
------------

// File: rtl/spi_slave.sv
// spi_slave: SPI frame deserialiser for the command RAM with MISO read-back.
// Optional SPI_CMD_CHECK_EN drops frames whose command bits do not match the decoded state.
module spi_slave #(
  parameter int DATA_W = 10,
  parameter int TX_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic [TX_W-1:0]   tx_data,
  input  logic              tx_valid
);
  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;
  state_t            r_state, w_next;
  logic              r_flag, r_wait;
  logic [3:0]        r_cnt, r_tx_cnt;
  logic [DATA_W-2:0] r_sh;
  logic [TX_W-1:0]   r_tx_sh;
  logic              w_rx, w_last, w_ok;
  logic [DATA_W-1:0] w_word;
  always_comb begin
    w_rx   = r_state inside {WRITE, READ_ADD, READ_DATA};
    w_last = w_rx && !SS_n && r_cnt == 4'(DATA_W-2);
    w_word = {r_sh, MOSI};
`ifdef SPI_CMD_CHECK_EN
    w_ok = r_state == WRITE    ? !w_word[DATA_W-1] :
           r_state == READ_ADD ? w_word[DATA_W-1 -: 2] == 2'b10 :
                                 w_word[DATA_W-1 -: 2] == 2'b11;
`else
    w_ok = 1'b1;
`endif
    w_next = (r_state != IDLE && SS_n)   ? IDLE :
             (r_state == IDLE && !SS_n)  ? CHK_CMD :
             (r_state == CHK_CMD)        ? (MOSI ? (r_flag ? READ_DATA : READ_ADD) : WRITE) :
                                           r_state;
  end
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flag   <= 1'b0;
      r_wait   <= 1'b0;
      r_cnt    <= '0;
      r_tx_cnt <= '0;
      r_sh     <= '0;
      r_tx_sh  <= '0;
      MISO     <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (w_next == IDLE) begin
        r_wait   <= 1'b0;
        r_cnt    <= '0;
        r_tx_cnt <= '0;
        r_sh     <= '0;
        r_tx_sh  <= '0;
        MISO     <= 1'b0;
      end else begin
        if (r_state == CHK_CMD || (w_rx && r_cnt < 4'(DATA_W-1))) r_sh <= {r_sh[DATA_W-3:0], MOSI};
        if (w_rx && r_cnt < 4'(DATA_W-1)) r_cnt <= r_cnt + 4'd1;
        if (w_last && w_ok) begin
          rx_data  <= w_word;
          rx_valid <= 1'b1;
          r_flag   <= r_state == READ_ADD ? 1'b1 : r_state == READ_DATA ? 1'b0 : r_flag;
          r_wait   <= r_state == READ_DATA;
        end
        // r_wait only arms after an accepted read-data frame, so tx_valid is ignored elsewhere
        if (r_wait && tx_valid) begin
          r_tx_sh  <= tx_data;
          r_tx_cnt <= 4'(TX_W);
          r_wait   <= 1'b0;
          MISO     <= 1'b0;
        end else if (r_tx_cnt != 4'd0) begin
          MISO     <= r_tx_sh[TX_W-1];
          r_tx_sh  <= {r_tx_sh[TX_W-2:0], 1'b0};
          r_tx_cnt <= r_tx_cnt - 4'd1;
        end else begin
          MISO     <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: randomized self-checking bench for spi_slave with a frame-level reference model.
module tb_spi_slave;
  logic       clk = 1'b0, rst = 1'b1, SS_n = 1'b1, MOSI = 1'b0, tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       MISO, rx_valid;
  logic [9:0] rx_data;
  int         n_cmp = 0, n_err = 0;
  logic       m_flag = 1'b0;
  logic [9:0] m_rx = 10'h000;
`ifdef SPI_CMD_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  spi_slave dut (
    .clk(clk), .rst(rst), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid)
  );

  always #5 clk = ~clk;

  // Called at a negedge; returns at a negedge with SS_n high.
  // kind: 0 write, 1 read-address, 2 read-data, chosen from bit 9 and the modelled flag.
  task automatic run_frame(input logic [9:0] w, input int abort_at, input int d,
                           input logic [7:0] b, input int rst_at);
    int  kind;
    bit  ok, aborted;
    kind = !w[9] ? 0 : (m_flag ? 2 : 1);
    ok = !CHK || kind == 0 || (kind == 1 && !w[8]) || (kind == 2 && w[8]);
    SS_n = 1'b0;
    MOSI = 1'($urandom_range(0, 1));
    aborted = 1'b0;
    for (int i = 0; i < 10 && !aborted; i++) begin
      @(negedge clk);
      n_cmp++;
      if (rx_valid !== 1'b0 || MISO !== 1'b0) begin
        n_err++;
        $display("FAIL frame_shift bit%0d: rx_valid=%b MISO=%b want 0 0", i, rx_valid, MISO);
      end
      if (i == abort_at) begin
        SS_n = 1'b1;
        aborted = 1'b1;
      end
      MOSI = w[9-i];
    end
    if (aborted) begin
      repeat (2) begin
        @(negedge clk);
        n_cmp++;
        if (rx_valid !== 1'b0 || MISO !== 1'b0) begin
          n_err++;
          $display("FAIL abort_quiet: rx_valid=%b MISO=%b want 0 0", rx_valid, MISO);
        end
      end
      n_cmp++;
      if (rx_data !== m_rx) begin
        n_err++;
        $display("FAIL abort_rx_data: got %h want %h", rx_data, m_rx);
      end
      return;
    end
    @(negedge clk);
    n_cmp++;
    if (rx_valid !== ok) begin
      n_err++;
      $display("FAIL strobe w=%h: rx_valid=%b want %b", w, rx_valid, ok);
    end
    if (ok) begin
      m_rx = w;
      n_cmp++;
      if (rx_data !== w) begin
        n_err++;
        $display("FAIL rx_data: got %h want %h", rx_data, w);
      end
      if (kind == 1) m_flag = 1'b1;
      if (kind == 2) m_flag = 1'b0;
    end
    if (ok && kind == 2) begin
      for (int j = 0; j < d; j++) begin
        MOSI = 1'($urandom_range(0, 1));
        @(negedge clk);
        n_cmp++;
        if (MISO !== 1'b0 || rx_valid !== 1'b0) begin
          n_err++;
          $display("FAIL tx_wait: MISO=%b rx_valid=%b want 0 0", MISO, rx_valid);
        end
      end
      tx_valid = 1'b1;
      tx_data  = b;
      @(negedge clk);
      tx_valid = 1'b0;
      tx_data  = 8'($urandom);
      n_cmp++;
      if (MISO !== 1'b0 || rx_valid !== 1'b0) begin
        n_err++;
        $display("FAIL tx_capture: MISO=%b rx_valid=%b want 0 0", MISO, rx_valid);
      end
      for (int k = 7; k >= 0; k--) begin
        if (7 - k == rst_at) begin
          rst  = 1'b1;
          SS_n = 1'b1;
          @(negedge clk);
          n_cmp++;
          if (MISO !== 1'b0 || rx_valid !== 1'b0 || rx_data !== 10'h000) begin
            n_err++;
            $display("FAIL reset_midread: MISO=%b rx_valid=%b rx_data=%h want 0 0 000", MISO, rx_valid, rx_data);
          end
          rst    = 1'b0;
          m_flag = 1'b0;
          m_rx   = 10'h000;
          return;
        end
        @(negedge clk);
        n_cmp++;
        if (MISO !== b[k]) begin
          n_err++;
          $display("FAIL miso_bit%0d data=%h: got %b want %b", k, b, MISO, b[k]);
        end
      end
      @(negedge clk);
      n_cmp++;
      if (MISO !== 1'b0) begin
        n_err++;
        $display("FAIL miso_after_tx: got %b want 0", MISO);
      end
    end
    tx_valid = 1'b1;
    tx_data  = 8'($urandom_range(1, 255));
    MOSI     = 1'($urandom_range(0, 1));
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      n_cmp++;
      if (MISO !== 1'b0 || rx_valid !== 1'b0) begin
        n_err++;
        $display("FAIL tx_ignored: MISO=%b rx_valid=%b want 0 0", MISO, rx_valid);
      end
    end
    SS_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (MISO !== 1'b0 || rx_valid !== 1'b0 || rx_data !== m_rx) begin
      n_err++;
      $display("FAIL frame_end: MISO=%b rx_valid=%b rx_data=%h want 0 0 %h", MISO, rx_valid, rx_data, m_rx);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; SS_n = 1'b0; MOSI = 1'b1; tx_valid = 1'b1; tx_data = 8'hFF;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (MISO !== 1'b0 || rx_valid !== 1'b0 || rx_data !== 10'h000) begin
        n_err++;
        $display("FAIL reset_state: MISO=%b rx_valid=%b rx_data=%h want 0 0 000", MISO, rx_valid, rx_data);
      end
    end
    rst = 1'b0; SS_n = 1'b1; tx_valid = 1'b0;
    m_flag = 1'b0; m_rx = 10'h000;
    @(negedge clk);
    n_cmp++;
    if (MISO !== 1'b0 || rx_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: MISO=%b rx_valid=%b want 0 0", MISO, rx_valid);
    end
  endtask

  task automatic test_write_frame();
    run_frame(10'b00_1010_0101, 10, 0, 8'h00, -1);
  endtask

  task automatic test_read_sequence();
    run_frame(10'b10_0000_0011, 10, 0, 8'h00, -1);
    run_frame({2'b11, 8'($urandom)}, 10, 0, 8'hC3, -1);
    run_frame(10'b10_0101_0000, 10, 2, 8'h00, -1);
    run_frame({2'b11, 8'($urandom)}, 10, 3, 8'h5A, -1);
  endtask

  task automatic test_read_without_addr();
    run_frame({2'b10, 8'($urandom)}, 10, 0, 8'hFF, -1);
    run_frame({2'b11, 8'($urandom)}, 10, 1, 8'h81, -1);
  endtask

  task automatic test_abort();
    run_frame({1'b0, 9'($urandom)}, 5, 0, 8'h00, -1);
    run_frame(10'b01_1100_0011, 10, 0, 8'h00, -1);
    run_frame({1'b0, 9'($urandom)}, 9, 0, 8'h00, -1);
    run_frame(10'b10_0000_0001, 10, 0, 8'h00, -1);
    run_frame({2'b11, 8'($urandom)}, 7, 0, 8'h00, -1);
    run_frame({2'b11, 8'($urandom)}, 10, 0, 8'hA5, -1);
  endtask

  task automatic test_reset_midread();
    run_frame(10'b10_0000_0111, 10, 0, 8'h00, -1);
    run_frame({2'b11, 8'($urandom)}, 10, 1, 8'hF0, 3);
    run_frame({2'b10, 8'($urandom)}, 10, 0, 8'hFF, -1);
  endtask

  task automatic test_cmd_check();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; m_flag = 1'b0; m_rx = 10'h000;
    run_frame(10'b11_0000_0001, 10, 0, 8'h00, -1);
    run_frame({2'b11, 8'($urandom)}, 10, 0, 8'h3C, -1);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 40; n++) begin
      run_frame(10'($urandom),
                ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 9)) : 10,
                int'($urandom_range(0, 3)), 8'($urandom), -1);
    end
  endtask

  initial begin
    test_reset();
    test_write_frame();
    test_read_sequence();
    test_read_without_addr();
    test_abort();
    test_reset_midread();
    test_cmd_check();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
